// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - fixed-priority interrupt controller with PENDING/MASK/CLAIM/EOI registers
// Define IRQC_SYNC_EN to put a two-flop synchronizer on every IRQ_I line ahead of edge detect.
module irq_ctrl #(
  parameter int NUM_SRC = 6,
  parameter int ID_W    = 5
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic [3:2]         ADD_I,
  input  logic               WE_I,
  input  logic [31:0]        DAT_I,
  output logic [31:0]        DAT_O,
  input  logic [NUM_SRC-1:0] IRQ_I,
  output logic               IRQ_O,
  output logic [ID_W-1:0]    ID_O
);

  typedef enum logic {IDLE = 1'b0, SERVICE = 1'b1} state_t;

  localparam logic [1:0] A_PEND  = 2'b00;
  localparam logic [1:0] A_MASK  = 2'b01;
  localparam logic [1:0] A_CLAIM = 2'b10;
  localparam logic [1:0] A_EOI   = 2'b11;

  state_t              state, state_next;
  logic                irq_next;
  logic [ID_W-1:0]     id_next;
  logic [ID_W-1:0]     lowest_id;
  logic [NUM_SRC-1:0]  pending, mask, irq_prev, irq_in;
  logic [NUM_SRC-1:0]  events, w1c_clr, eoi_clr;
  logic                eoi_wr, any_req;
  logic                unused_dat;

  assign unused_dat = ^DAT_I;

`ifdef IRQC_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= IRQ_I;
      sync2 <= sync1;
    end
  end

  assign irq_in = sync2;
`else
  assign irq_in = IRQ_I;
`endif

  // Rising-edge detect: a level held high produces a single event.
  assign events  = irq_in & ~irq_prev;
  assign w1c_clr = (WE_I && ADD_I == A_PEND) ? DAT_I[NUM_SRC-1:0] : '0;
  assign eoi_wr  = WE_I && (ADD_I == A_EOI) && (state == SERVICE);
  assign any_req = |(pending & mask);

  always_comb begin
    eoi_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eoi_clr[i] = eoi_wr && (ID_O == ID_W'(i));
    end
  end

  always_comb begin
    lowest_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i] && mask[i]) lowest_id = ID_W'(i);
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      irq_prev <= '0;
      pending  <= '0;
      mask     <= '0;
    end else begin
      irq_prev <= irq_in;
      // New events win over same-cycle W1C or EOI clears.
      pending  <= (pending & ~(w1c_clr | eoi_clr)) | events;
      if (WE_I && ADD_I == A_MASK) mask <= DAT_I[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state <= IDLE;
      IRQ_O <= 1'b0;
      ID_O  <= '0;
    end else begin
      state <= state_next;
      IRQ_O <= irq_next;
      ID_O  <= id_next;
    end
  end

  always_comb begin
    state_next = state;
    irq_next   = IRQ_O;
    id_next    = ID_O;
    case (state)
      IDLE: begin
        irq_next = 1'b0;
        if (any_req) begin
          state_next = SERVICE;
          irq_next   = 1'b1;
          id_next    = lowest_id;
        end
      end
      SERVICE: begin
        irq_next = 1'b1;
        if (eoi_wr) begin
          state_next = IDLE;
          irq_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        irq_next   = 1'b0;
      end
    endcase
  end

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      A_PEND:  DAT_O[NUM_SRC-1:0] = pending;
      A_MASK:  DAT_O[NUM_SRC-1:0] = mask;
      A_CLAIM: begin
        DAT_O[31]       = (state == SERVICE);
        DAT_O[ID_W-1:0] = ID_O;
      end
      default: DAT_O = '0;
    endcase
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Memory-mapped interrupt controller that sits between the bus bridge and the CPU interrupt input. It collects IRQ pulses from up to NUM_SRC peripherals (timer0, timer1, UART, ...) and latches them as pending. It arbitrates among unmasked pending sources with fixed priority and presents one claimed source at a time to the CPU. It holds that source in service until software writes end-of-interrupt (EOI).

Parameters:
NUM_SRC, 6, number of interrupt sources; legal range 1..32; source 0 has the highest priority.
ID_W, 5, width of the claimed-source index; must satisfy 2^ID_W >= NUM_SRC.

Ports:
CLK_I  input  1  system clock; all state updates on rising edge.
RST_I  input  1  asynchronous, active-low reset.
ADD_I  input  [3:2]  word select: 00 PENDING, 01 MASK, 10 CLAIM, 11 EOI.
WE_I  input  1  write strobe; a write is qualified on the rising clock edge.
DAT_I  input  32  write data.
DAT_O  output  32  read data; combinational from ADD_I; unused bits read 0.
IRQ_I  input  NUM_SRC  peripheral interrupt lines; pulse or level.
IRQ_O  output  1  interrupt request to the CPU; registered.
ID_O  output  ID_W  index of the source in service; registered.

Behaviour:
- Reset (RST_I=0, asynchronous): pending=0, mask=0 (all masked), irq_prev=0, state=IDLE, IRQ_O=0, ID_O=0.
- Edge detect: the block registers irq_prev<=IRQ_I each cycle. A source event is IRQ_I[i]&~irq_prev[i], so a level held high counts once. A line already high when reset is released counts as one event.
- PENDING (00): read returns pending. Write is write-1-to-clear. If an event and a W1C hit the same bit in the same cycle, set wins.
- MASK (01): read/write, bits [NUM_SRC-1:0]; 1 = enabled. Masking does not clear pending.
- CLAIM (10): read only. Returns {in_service bit31, zeros, ID_O in [ID_W-1:0]}. Writes are ignored.
- EOI (11): write only; data is ignored; reads return 0.
- FSM, two states:
  - IDLE: if (pending & mask) != 0, go to SERVICE on the next edge. ID_O <= lowest set index. IRQ_O <= 1.
  - SERVICE: IRQ_O stays 1 and ID_O is frozen. An EOI write clears pending[ID_O] and sets IRQ_O <= 0. State returns to IDLE. A new event on source ID_O in the same EOI cycle re-sets pending (set wins).
- Latency: an event sampled at edge k sets pending after edge k. IRQ_O rises after edge k+1 (2 cycles).
- After EOI at edge m, IRQ_O is low for exactly one cycle. If more work is pending, IRQ_O re-asserts after edge m+1 with the next-priority ID.
- No preemption: a higher-priority event during SERVICE stays pending until EOI.
- Masking or W1C-clearing the in-service source during SERVICE does not release it; only EOI does.
- EOI written in IDLE is ignored; no pending bit changes.
- Reset asserted mid-SERVICE returns everything to reset values immediately.

Optional Feature:
IRQC_SYNC_EN:
- Defined: each IRQ_I bit passes through a two-flop synchronizer before edge detect. Event-to-IRQ_O latency becomes 4 cycles. Synchronizer flops reset to 0.
- Undefined: IRQ_I feeds edge detect directly, with the 2-cycle latency above.

Test Plan:
1. Reset, MASK=0x3F, 1-cycle pulse on IRQ_I[2] -> PENDING=0x04. IRQ_O=1 and ID_O=2 two cycles after the sampling edge. CLAIM reads 0x80000002.
2. Simultaneous pulses on IRQ_I[1] and IRQ_I[4] with MASK=0x3F -> ID_O=1 first. EOI -> IRQ_O low for one cycle, then ID_O=4. Second EOI -> IRQ_O=0, PENDING=0.
3. MASK=0x00, pulse IRQ_I[0] -> PENDING=0x01, IRQ_O stays 0. Write MASK=0x01 -> IRQ_O=1 on the next edge, ID_O=0.
4. IRQ_I[3] held high for 20 cycles with EOI written at cycle 10 -> exactly one event. PENDING[3]=0 after EOI and IRQ_O=0.
5. In SERVICE with ID_O=5, write PENDING=0x20 and MASK=0 -> IRQ_O stays 1. EOI -> IRQ_O=0. An EOI written in IDLE leaves PENDING unchanged.
6. Drop RST_I asynchronously mid-SERVICE -> IRQ_O=0, PENDING=0, MASK=0 immediately, without waiting for a clock edge.
